// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates uart_rx, captures bytes into a FWFT FIFO, flags overrun.
// Optional line-idle timeout pulse when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned IDLE_CHARS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic                       rx_en,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overrun,
    input  logic                       ovr_clr,
    input  logic                       flush,
    output logic                       idle_timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TO_CYC =
        32'((64'(IDLE_CHARS) * 64'd10 * 64'(CLK_FREQ)) / 64'(BAUD_RATE));

    typedef enum logic {OFF = 1'b0, ON = 1'b1} state_t;

    state_t          state;
    logic            rx_valid_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [DEPTH];

    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;

    assign push      = rx_valid & ~rx_valid_q;
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (level == LW'(DEPTH));
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign wr_en     = push & (~full | pop) & ~flush;
    assign out_data  = mem[rd_ptr];

    // Control FSM: rx_en follows enable one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OFF;
            rx_en <= 1'b0;
        end else begin
            case (state)
                OFF: if (enable) begin
                    state <= ON;
                    rx_en <= 1'b1;
                end
                ON: if (!enable) begin
                    state <= OFF;
                    rx_en <= 1'b0;
                end
                default: begin
                    state <= OFF;
                    rx_en <= 1'b0;
                end
            endcase
        end
    end

    // Edge detector on the level-style rx_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_valid_q <= 1'b0;
        else       rx_valid_q <= rx_valid;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_data;
    end

    // Pointers, occupancy and sticky overrun; flush dominates everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && full && !pop) overrun <= 1'b1;
            else if (ovr_clr)         overrun <= 1'b0;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TO_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          to_pulse;

    // Counts idle cycles while data waits; saturates at TO_CYC after one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else if (push || pop || flush || level == '0) begin
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else if (to_cnt != TW'(TO_CYC)) begin
            to_cnt   <= to_cnt + TW'(1);
            to_pulse <= (to_cnt == TW'(TO_CYC - 1));
        end else begin
            to_pulse <= 1'b0;
        end
    end

    assign idle_timeout = to_pulse;
`else
    logic [31:0] to_cyc_unused;
    assign to_cyc_unused = TO_CYC;
    assign idle_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl (DEPTH=4, timeout sized to 100 cycles).
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       rx_en;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       overrun;
    logic       ovr_clr = 1'b0;
    logic       flush = 1'b0;
    logic       idle_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    uart_rx_ctrl #(
        .DEPTH(4), .CLK_FREQ(1000), .BAUD_RATE(100), .IDLE_CHARS(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx_en(rx_en),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .overrun(overrun), .ovr_clr(ovr_clr), .flush(flush),
        .idle_timeout(idle_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One rising edge on rx_valid; queued only if the bench expects it stored.
    task automatic send(input logic [7:0] b, input bit keep);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        if (keep) exp_q.push_back(b);
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            tick();
        end
        out_ready = 1'b0;
        check("drain_done", 32'(out_valid), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Each accepted pop is compared against the oldest queued byte.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(out_data), 32'hFFFF);
            else                   check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int pulses;
        int first_at;

        #1;
        check("rst_rx_en", 32'(rx_en), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(idle_timeout), 0);
        tick(); tick();
        reset  = 1'b0;
        enable = 1'b1;
        check("rx_en_latency", 32'(rx_en), 0);
        tick();
        check("rx_en_on", 32'(rx_en), 1);

        // Basic capture then drain in order.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        tick();
        check("fwft_valid", 32'(out_valid), 1);
        check("fwft_data", 32'(out_data), 32'hA5);
        rx_valid = 1'b0;
        exp_q.push_back(8'hA5);
        tick();
        send(8'h3C, 1);
        send(8'hFF, 1);
        check("t1_level", 32'(level), 3);
        check("t1_head", 32'(out_data), 32'hA5);
        drain();
        check("t1_level_end", 32'(level), 0);

        // Long rx_valid hold while disabled still yields exactly one byte.
        enable = 1'b0;
        tick();
        check("rx_en_off", 32'(rx_en), 0);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        rx_valid = 1'b0;
        exp_q.push_back(8'h5A);
        tick();
        check("t2_level", 32'(level), 1);
        drain();
        enable = 1'b1;

        // Overrun on full, clear, and set-over-clear priority.
        send(8'h11, 1);
        send(8'h22, 1);
        send(8'h33, 1);
        send(8'h44, 1);
        check("t3_overrun_pre", 32'(overrun), 0);
        send(8'h77, 0);
        check("t3_level", 32'(level), 4);
        check("t3_overrun", 32'(overrun), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t3_ovr_clr", 32'(overrun), 0);
        rx_data  = 8'h88;
        rx_valid = 1'b1;
        ovr_clr  = 1'b1;
        tick();
        rx_valid = 1'b0;
        ovr_clr  = 1'b0;
        check("t3_set_priority", 32'(overrun), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t3_ovr_clr2", 32'(overrun), 0);

        // Push and pop on the same edge while full.
        rx_data   = 8'h11;
        rx_valid  = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(8'h11);
        tick();
        rx_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check("t4_level", 32'(level), 4);
        check("t4_overrun", 32'(overrun), 0);
        drain();

        // Flush coincident with a push.
        send(8'hA1, 1);
        send(8'hA2, 1);
        send(8'hA3, 1);
        send(8'hA4, 1);
        send(8'hA5, 0);
        check("t5_ovr_set", 32'(overrun), 1);
        rx_data  = 8'hB0;
        rx_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        rx_valid = 1'b0;
        exp_q.delete();
        check("t5_level", 32'(level), 0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_overrun", 32'(overrun), 0);
        tick();
        check("t5_no_late_push", 32'(level), 0);

        // Asynchronous reset in the middle of a drain.
        send(8'hC1, 1);
        send(8'hC2, 1);
        send(8'hC3, 1);
        out_ready = 1'b1;
        tick();
        check("t5_mid_level", 32'(level), 2);
        reset = 1'b1;
        #1;
        check("t5_rst_level", 32'(level), 0);
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_rx_en", 32'(rx_en), 0);
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();

        // Idle timeout: single pulse 100 cycles after the push edge, none when empty.
        rx_data  = 8'h42;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        exp_q.push_back(8'h42);
        pulses   = 0;
        first_at = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (idle_timeout) begin
                pulses++;
                if (first_at < 0) first_at = n;
            end
        end
`ifdef UART_RX_CTRL_TIMEOUT_EN
        check("t6_pulse_count", 32'(pulses), 1);
        check("t6_pulse_at", 32'(first_at), 100);
`else
        check("t6_no_pulse", 32'(pulses), 0);
`endif
        drain();
        pulses = 0;
        for (int n = 0; n < 150; n++) begin
            tick();
            if (idle_timeout) pulses++;
        end
        check("t6_empty_quiet", 32'(pulses), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
